// File: rtl/rcpu_pkg.sv
// rtl/rcpu_pkg.sv - shared constants and requester ids for the j1 RAM subsystem
package rcpu_pkg;

    localparam int WORD_W    = 16;
    localparam int RAM_DEPTH = 4096;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DMA = 1'b1
    } req_id_e;

endpackage

// File: rtl/ram_arbiter_if.sv
// rtl/ram_arbiter_if.sv - CPU, DMA and RAM-side signal bundle for ram_arbiter
//
// slave  : the arbiter (takes requests and RAM read data, drives grants,
//          responses, RAM strobes/address/data and err)
// master : the surrounding system (CPU, DMA/loader and the RAM itself)
interface ram_arbiter_if;
    import rcpu_pkg::*;

    logic              c_req;
    logic              c_we;
    logic [WORD_W-1:0] c_addr;
    logic [WORD_W-1:0] c_wdata;
    logic              c_gnt;
    logic              c_rvalid;
    logic [WORD_W-1:0] c_rdata;

    logic              d_req;
    logic              d_we;
    logic [WORD_W-1:0] d_addr;
    logic [WORD_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [WORD_W-1:0] d_rdata;

    logic              mem_read_enable;
    logic              mem_write_enable;
    logic [WORD_W-1:0] mem_read_address;
    logic [WORD_W-1:0] mem_write_address;
    logic [WORD_W-1:0] mem_write_data;
    logic [WORD_W-1:0] mem_read_data;

    logic              err;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        output c_gnt, c_rvalid, c_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_read_enable, mem_write_enable,
        output mem_read_address, mem_write_address, mem_write_data,
        input  mem_read_data,
        output err
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata,
        input  c_gnt, c_rvalid, c_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_read_enable, mem_write_enable,
        input  mem_read_address, mem_write_address, mem_write_data,
        output mem_read_data,
        input  err
    );

endinterface

// File: rtl/arb_priority.sv
// rtl/arb_priority.sv - CPU-priority grant decision with DMA starvation counter
//
// clk, resetq : clock, synchronous active-low reset
// i_c_req     : CPU request
// i_d_req     : DMA request
// o_c_gnt     : CPU granted this cycle (combinational)
// o_d_gnt     : DMA granted this cycle (combinational)
module arb_priority #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic resetq,
    input  logic i_c_req,
    input  logic i_d_req,
    output logic o_c_gnt,
    output logic o_d_gnt
);

    localparam int              CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] r_starve_cnt;
    logic             w_starved;

    assign w_starved = (r_starve_cnt == LIMIT);

    // A starved DMA request overrides CPU priority for exactly one grant.
    always_comb begin
        o_c_gnt = 1'b0;
        o_d_gnt = 1'b0;
        if (resetq) begin
            if (i_d_req && w_starved) begin
                o_d_gnt = 1'b1;
            end else if (i_c_req) begin
                o_c_gnt = 1'b1;
            end else if (i_d_req) begin
                o_d_gnt = 1'b1;
            end
        end
    end

    // Counts consecutive denied DMA cycles; any DMA grant or idle DMA restarts it.
    always_ff @(posedge clk) begin
        if (!resetq) begin
            r_starve_cnt <= '0;
        end else if (i_d_req && !o_d_gnt) begin
            if (!w_starved) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
        end else begin
            r_starve_cnt <= '0;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - shares the j1 program/data RAM between CPU and DMA ports
//
// clk, resetq : clock, synchronous active-low reset
// bus         : slave side of ram_arbiter_if (CPU/DMA request and response
//               channels, RAM strobes/address/data, sticky err flag)
module ram_arbiter
    import rcpu_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_LIMIT   = RAM_DEPTH
) (
    input  logic           clk,
    input  logic           resetq,
    ram_arbiter_if.slave   bus
);

    localparam logic [WORD_W:0] ADDR_LIM = (WORD_W + 1)'(ADDR_LIMIT);

    logic              w_c_gnt;
    logic              w_d_gnt;
    logic              w_gnt;
    logic              w_we;
    logic              w_in_range;
    logic [WORD_W-1:0] w_addr;
    logic [WORD_W-1:0] w_wdata;
    req_id_e           w_sel;
    logic              w_c_rvalid;
    logic              w_d_rvalid;

    logic              r_rpend;
    req_id_e           r_rsel;
    logic              r_roob;
    logic              r_err;

    arb_priority #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb (
        .clk     (clk),
        .resetq  (resetq),
        .i_c_req (bus.c_req),
        .i_d_req (bus.d_req),
        .o_c_gnt (w_c_gnt),
        .o_d_gnt (w_d_gnt)
    );

    assign bus.c_gnt = w_c_gnt;
    assign bus.d_gnt = w_d_gnt;

    assign w_gnt      = w_c_gnt | w_d_gnt;
    assign w_sel      = w_d_gnt ? REQ_DMA : REQ_CPU;
    assign w_we       = w_d_gnt ? bus.d_we    : bus.c_we;
    assign w_addr     = w_d_gnt ? bus.d_addr  : bus.c_addr;
    assign w_wdata    = w_d_gnt ? bus.d_wdata : bus.c_wdata;
    assign w_in_range = ({1'b0, w_addr} < ADDR_LIM);

    // RAM ports are driven only by an in-range winner; otherwise everything idles at zero.
    always_comb begin
        bus.mem_read_enable   = 1'b0;
        bus.mem_write_enable  = 1'b0;
        bus.mem_read_address  = '0;
        bus.mem_write_address = '0;
        bus.mem_write_data    = '0;
        if (w_gnt && w_in_range) begin
            if (w_we) begin
                bus.mem_write_enable  = 1'b1;
                bus.mem_write_address = w_addr;
                bus.mem_write_data    = w_wdata;
            end else begin
                bus.mem_read_enable  = 1'b1;
                bus.mem_read_address = w_addr;
            end
        end
    end

    // Response tracking lines up with the RAM's one-cycle read latency.
    // Out-of-range reads still complete, but the data is forced to zero.
    always_ff @(posedge clk) begin
        if (!resetq) begin
            r_rpend <= 1'b0;
            r_rsel  <= REQ_CPU;
            r_roob  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_rpend <= w_gnt & ~w_we;
            r_rsel  <= w_sel;
            r_roob  <= ~w_in_range;
            if (w_gnt && !w_in_range) begin
                r_err <= 1'b1;
            end
        end
    end

    assign w_c_rvalid = r_rpend && (r_rsel == REQ_CPU);
    assign w_d_rvalid = r_rpend && (r_rsel == REQ_DMA);

    assign bus.c_rvalid = w_c_rvalid;
    assign bus.d_rvalid = w_d_rvalid;
    assign bus.c_rdata  = (w_c_rvalid && !r_roob) ? bus.mem_read_data : '0;
    assign bus.d_rdata  = (w_d_rvalid && !r_roob) ? bus.mem_read_data : '0;
    assign bus.err      = r_err;

endmodule
